fwrisc_mem_arbiter: RTL and testbench
=====================================

# fwrisc_mem_arbiter

Shares a single unified memory port between the instruction-fetch port and the data port of an fwrisc core. Both core ports use a valid/ready handshake. The arbiter serializes them onto one registered memory request with at most one transaction outstanding. Data accesses have priority over fetches, with optional starvation protection for fetches. It sits between the fwrisc core boundary and a single-ported SRAM or bus bridge.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending (1..7); used only when the starvation feature is compiled in.

Ports:
- clock  in  1  system clock; all state is on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_addr  in  32  fetch address
- i_valid  in  1  fetch request
- i_rdata  out  32  fetch data; valid while i_ready=1
- i_ready  out  1  one-cycle fetch completion pulse
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_wstb  in  4  byte write strobes
- d_write  in  1  1=write, 0=read
- d_valid  in  1  data request
- d_rdata  out  32  read data; valid while d_ready=1
- d_ready  out  1  one-cycle data completion pulse
- m_valid  out  1  memory request
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_wstb  out  4  memory strobes
- m_write  out  1  memory write enable
- m_rdata  in  32  memory read data; sampled when m_ready=1
- m_ready  in  1  memory completion for the current request

## Operation
- The FSM has three states: IDLE, BUSY, RESP. A registered owner bit (I or D) records which port holds the current transaction.
- **IDLE:** the arbiter samples i_valid and d_valid.
  - If either is set, it selects a winner.
  - It registers m_addr, m_wdata, m_wstb and m_write from the winner and sets m_valid=1. The FSM moves to BUSY.
  - For a fetch, m_wdata=0, m_wstb=0 and m_write=0.
- **BUSY:** all m_* outputs are held stable until m_ready=1.
  - On m_ready=1, the arbiter captures m_rdata, clears m_valid and moves to RESP.
- **RESP:** the owner's ready output is 1 for exactly one cycle and its rdata equals the captured word. The other port's ready stays 0.
  - Requests are ignored in this cycle, because the requester may still hold valid for the completed transfer.
  - The FSM returns to IDLE.
- i_rdata and d_rdata are 0 whenever the matching ready is 0.
- **Winner selection:**
  - d_valid alone: grant D.
  - i_valid alone: grant I.
  - Both set: grant D, except for the starvation rule under Configuration.
- **Starvation counter:** starve_cnt is a 3-bit counter.
  - It increments on a D grant when i_valid=1.
  - It clears on any I grant, and on a D grant when i_valid=0.
  - It saturates at 7.
- Mid-transaction changes on the i_* or d_* inputs are ignored; the latched request is used.

## Timing
- Reset values: m_valid=0, m_addr=0, m_wdata=0, m_wstb=0, m_write=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, state=IDLE, starve_cnt=0.
- Request sampled in IDLE at cycle N → m_valid=1 at cycle N+1.
- m_ready=1 at cycle N+1+k → owner ready=1 at cycle N+2+k.
- Minimum latency is 2 cycles (k=0).
- Earliest next IDLE sample is at N+3+k. Back-to-back throughput is one transaction per 3 cycles at zero wait states.
- m_ready while m_valid=0 is ignored.
- Reset asserted in any state:
  - All outputs go to their reset values asynchronously and the transaction is abandoned.
  - No ready pulse is generated after reset release.
  - The memory side must tolerate the withdrawn request.

## Configuration
- FWRISC_MEM_ARB_STARVE_EN defined:
  - In IDLE, if both valids are set and starve_cnt >= STARVE_LIMIT, the arbiter grants I.
  - A continuously pending fetch is therefore served at least once every STARVE_LIMIT+1 grants.
- Not defined:
  - The arbiter uses strict data priority.
  - starve_cnt is not instantiated and STARVE_LIMIT is unused.

## Test plan
- **Reset:** assert reset mid-simulation with random inputs → all outputs 0 within the same cycle. After release, no ready pulse until a new request.
- **Single fetch:** i_addr=0x80000000, i_valid=1, memory returns m_ready=1 in the same cycle as m_valid with m_rdata=0x00000013 → m_addr=0x80000000, m_write=0, m_wstb=0 at N+1. i_ready=1 and i_rdata=0x00000013 at N+2 only.
- **Simultaneous requests:** i_valid and d_valid both set; data is a write, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstb=0xF → first memory transaction is the write with m_write=1, d_ready pulses. Second is the fetch, i_ready pulses. No overlap between the two.
- **Wait states:** m_ready held 0 for 5 cycles during a read of 0x204 → m_valid, m_addr and m_write stay stable for 6 cycles. d_ready pulses once, 1 cycle after m_ready, with d_rdata=m_rdata.
- **Starvation (STARVE_LIMIT=2):** d_valid and i_valid held continuously.
  - With the macro defined → grant sequence D,D,I,D,D,I.
  - With the macro undefined → D only.
- **Reset mid-BUSY:** assert reset while m_valid=1 and m_ready=0 → m_valid drops asynchronously. After release, the state is IDLE and neither i_ready nor d_ready pulses.

Source files
------------

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter: shares one registered memory port between the fwrisc fetch and data ports.
// Optional macro FWRISC_MEM_ARB_STARVE_EN lets a waiting fetch win after STARVE_LIMIT data grants.

module fwrisc_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] i_addr,
    input  logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_ready,

    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstb,
    input  logic        d_write,
    input  logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstb,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_m_valid;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [3:0]  r_m_wstb;
    logic        r_m_write;
    logic [31:0] r_rdata;

    logic        w_request;
    logic        w_grant_d;
    logic        w_resp;

    assign w_request = i_valid || d_valid;

`ifdef FWRISC_MEM_ARB_STARVE_EN
    localparam logic [2:0] L_STARVE_LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] r_starve_cnt;
    logic       w_starved;

    // A fetch that has watched STARVE_LIMIT data grants in a row takes the next slot.
    assign w_starved = i_valid && (r_starve_cnt >= L_STARVE_LIMIT);
    assign w_grant_d = d_valid && !w_starved;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
        end else if (r_state == ST_IDLE && w_request) begin
            if (w_grant_d && i_valid) begin
                if (r_starve_cnt != 3'd7)
                    r_starve_cnt <= r_starve_cnt + 3'd1;
            end else begin
                r_starve_cnt <= 3'd0;
            end
        end
    end
`else
    logic w_unused_limit;

    assign w_grant_d      = d_valid;
    assign w_unused_limit = (STARVE_LIMIT != 0);
`endif

    // NOTE: non-blocking assignments make every register see pre-edge values, so the
    // request fields and the state update always agree on the same sampled inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_I;
            r_m_valid <= 1'b0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
            r_m_wstb  <= 4'd0;
            r_m_write <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        r_m_valid <= 1'b1;
                        r_state   <= ST_BUSY;
                        r_owner   <= w_grant_d ? OWN_D : OWN_I;
                        if (w_grant_d) begin
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                            r_m_wstb  <= d_wstb;
                            r_m_write <= d_write;
                        end else begin
                            r_m_addr  <= i_addr;
                            r_m_wdata <= 32'd0;
                            r_m_wstb  <= 4'd0;
                            r_m_write <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (m_ready) begin
                        r_rdata   <= m_rdata;
                        r_m_valid <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Requesters may still hold valid for the finished transfer here.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_resp  = (r_state == ST_RESP);
    assign i_ready = w_resp && (r_owner == OWN_I);
    assign d_ready = w_resp && (r_owner == OWN_D);
    assign i_rdata = i_ready ? r_rdata : 32'd0;
    assign d_rdata = d_ready ? r_rdata : 32'd0;

    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstb  = r_m_wstb;
    assign m_write = r_m_write;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Scoreboard bench for fwrisc_mem_arbiter: port drivers queue requests, a transaction-level
// model predicts grants and responses, and a monitor compares every cycle after the edge.

module tb_fwrisc_mem_arbiter;

    localparam int unsigned LIMIT = 2;
`ifdef FWRISC_MEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clock;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstb;
    logic        d_write;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstb;
    logic        m_write;
    logic [31:0] m_rdata;
    logic        m_ready;

    fwrisc_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock   (clock),
        .reset   (rst),
        .i_addr  (i_addr),
        .i_valid (i_valid),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstb  (d_wstb),
        .d_write (d_write),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstb  (m_wstb),
        .m_write (m_write),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        logic        write;
        int unsigned gap;
    } req_t;

    typedef struct {
        int unsigned wait_cycles;
        logic [31:0] data;
    } mem_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } resp_t;

    typedef enum {P_IDLE, P_BUSY, P_RESP} phase_e;

    int    n_checks = 0;
    int    n_err    = 0;

    req_t  stim_i_q[$];
    req_t  stim_d_q[$];
    req_t  req_i_q[$];
    req_t  req_d_q[$];
    mem_t  mem_q[$];
    resp_t exp_q[$];
    bit    grant_log[$];
    bit    exp_seq[6];

    bit    pend_i = 1'b0;
    bit    pend_d = 1'b0;
    bit    gnt_i  = 1'b0;
    bit    gnt_d  = 1'b0;
    bit    junk_en = 1'b0;
    int    mv_cycles = 0;

    phase_e      ph = P_IDLE;
    int unsigned starve = 0;
    req_t        cur;
    bit          cur_d;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_req(input string tag);
        check({tag, " m_addr"}, m_addr, cur.addr);
        check({tag, " m_wdata"}, m_wdata, cur.wdata);
        check({tag, " m_wstb"}, {28'd0, m_wstb}, {28'd0, cur.wstb});
        check_bit({tag, " m_write"}, m_write, cur.write);
    endtask

    // Fetch-port driver: holds valid until its ready pulse, scrambles the address once granted.
    initial begin
        req_t t;
        i_valid = 1'b0;
        i_addr  = 32'd0;
        forever begin
            @(negedge clock);
            if (rst) begin
                i_valid = 1'b0;
                pend_i  = 1'b0;
                gnt_i   = 1'b0;
            end else begin
                if (pend_i && i_ready) begin
                    pend_i  = 1'b0;
                    gnt_i   = 1'b0;
                    i_valid = 1'b0;
                end
                if (!pend_i && stim_i_q.size() > 0) begin
                    t = stim_i_q[0];
                    if (t.gap == 0) begin
                        void'(stim_i_q.pop_front());
                        i_addr  = t.addr;
                        i_valid = 1'b1;
                        pend_i  = 1'b1;
                        t.wdata = 32'd0;
                        t.wstb  = 4'd0;
                        t.write = 1'b0;
                        req_i_q.push_back(t);
                    end else begin
                        t.gap--;
                        stim_i_q[0] = t;
                    end
                end
                if (!pend_i || gnt_i)
                    i_addr = $urandom;
            end
        end
    end

    // Data-port driver: same protocol as the fetch driver.
    initial begin
        req_t t;
        d_valid = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        d_wstb  = 4'd0;
        d_write = 1'b0;
        forever begin
            @(negedge clock);
            if (rst) begin
                d_valid = 1'b0;
                pend_d  = 1'b0;
                gnt_d   = 1'b0;
            end else begin
                if (pend_d && d_ready) begin
                    pend_d  = 1'b0;
                    gnt_d   = 1'b0;
                    d_valid = 1'b0;
                end
                if (!pend_d && stim_d_q.size() > 0) begin
                    t = stim_d_q[0];
                    if (t.gap == 0) begin
                        void'(stim_d_q.pop_front());
                        d_addr  = t.addr;
                        d_wdata = t.wdata;
                        d_wstb  = t.wstb;
                        d_write = t.write;
                        d_valid = 1'b1;
                        pend_d  = 1'b1;
                        req_d_q.push_back(t);
                    end else begin
                        t.gap--;
                        stim_d_q[0] = t;
                    end
                end
                if (!pend_d || gnt_d) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_wstb  = 4'($urandom);
                    d_write = 1'($urandom);
                end
            end
        end
    end

    // Memory responder: directed wait/data from mem_q, otherwise random wait states.
    initial begin
        int          rw;
        logic [31:0] rd;
        mem_t        mt;
        rw      = -1;
        rd      = 32'd0;
        m_ready = 1'b0;
        m_rdata = 32'd0;
        forever begin
            @(negedge clock);
            if (rst) begin
                rw      = -1;
                m_ready = 1'b0;
            end else if (m_valid) begin
                mv_cycles++;
                if (rw < 0) begin
                    if (mem_q.size() > 0) begin
                        mt = mem_q.pop_front();
                        rw = int'(mt.wait_cycles);
                        rd = mt.data;
                    end else begin
                        rw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
                        rd = $urandom;
                    end
                end
                if (rw == 0) begin
                    m_ready = 1'b1;
                    m_rdata = rd;
                end else begin
                    m_ready = 1'b0;
                    m_rdata = $urandom;
                    rw--;
                end
            end else begin
                rw      = -1;
                m_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
                m_rdata = $urandom;
            end
        end
    end

    // Monitor and reference model: one step per clock edge, compared 1 time unit later.
    initial begin
        phase_e pre_ph;
        bit     mr, si, sd, win_d;
        logic [31:0] md;
        resp_t  r;
        forever begin
            @(posedge clock);
            if (rst) begin
                ph     = P_IDLE;
                starve = 0;
                req_i_q.delete();
                req_d_q.delete();
                exp_q.delete();
                continue;
            end
            pre_ph = ph;
            mr     = m_ready;
            md     = m_rdata;
            si     = (req_i_q.size() != 0);
            sd     = (req_d_q.size() != 0);
            #1;
            case (pre_ph)
                P_IDLE: begin
                    if (si || sd) begin
                        win_d = sd && !(STARVE_ON && si && starve >= LIMIT);
                        if (win_d) begin
                            cur    = req_d_q.pop_front();
                            starve = si ? ((starve < 7) ? starve + 1 : 7) : 0;
                            gnt_d  = 1'b1;
                        end else begin
                            cur    = req_i_q.pop_front();
                            starve = 0;
                            gnt_i  = 1'b1;
                        end
                        cur_d = win_d;
                        grant_log.push_back(win_d);
                        check_bit("m_valid on grant", m_valid, 1'b1);
                        check_req("grant");
                        ph = P_BUSY;
                    end else begin
                        check_bit("m_valid while idle", m_valid, 1'b0);
                    end
                end
                P_BUSY: begin
                    if (mr) begin
                        exp_q.push_back('{is_d: cur_d, data: md});
                        check_bit("m_valid after m_ready", m_valid, 1'b0);
                        ph = P_RESP;
                    end else begin
                        check_bit("m_valid held", m_valid, 1'b1);
                        check_req("hold");
                    end
                end
                default: begin
                    check_bit("m_valid in resp", m_valid, 1'b0);
                    ph = P_IDLE;
                end
            endcase

            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check_bit("i_ready pulse", i_ready, !r.is_d);
                check_bit("d_ready pulse", d_ready, r.is_d);
                check("owner rdata", r.is_d ? d_rdata : i_rdata, r.data);
                check("other rdata", r.is_d ? i_rdata : d_rdata, 32'd0);
            end else if (i_ready || d_ready) begin
                check_bit("unexpected i_ready", i_ready, 1'b0);
                check_bit("unexpected d_ready", d_ready, 1'b0);
            end else begin
                check("i_rdata without ready", i_rdata, 32'd0);
                check("d_rdata without ready", d_rdata, 32'd0);
            end
        end
    end

    task automatic do_reset(input int unsigned hold);
        rst = 1'b1;
        #1;
        check_bit("reset m_valid", m_valid, 1'b0);
        check("reset m_addr", m_addr, 32'd0);
        check("reset m_wdata", m_wdata, 32'd0);
        check("reset m_wstb", {28'd0, m_wstb}, 32'd0);
        check_bit("reset m_write", m_write, 1'b0);
        check_bit("reset i_ready", i_ready, 1'b0);
        check_bit("reset d_ready", d_ready, 1'b0);
        check("reset i_rdata", i_rdata, 32'd0);
        check("reset d_rdata", d_rdata, 32'd0);
        stim_i_q.delete();
        stim_d_q.delete();
        mem_q.delete();
        repeat (hold) @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic wait_quiet(input string what);
        int n;
        n = 0;
        while ((stim_i_q.size() != 0 || stim_d_q.size() != 0 || pend_i || pend_d || ph != P_IDLE)
               && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check_bit({what, " completes in budget"}, n < 2000, 1'b1);
        @(negedge clock);
        #1;
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                input logic w, input int unsigned g);
        req_t t;
        t.addr = a; t.wdata = wd; t.wstb = ws; t.write = w; t.gap = g;
        return t;
    endfunction

    function automatic req_t rnd_req();
        return mk($urandom, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 3));
    endfunction

    task automatic push_random(input int n);
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 2))
                0:       stim_i_q.push_back(rnd_req());
                1:       stim_d_q.push_back(rnd_req());
                default: begin
                    stim_i_q.push_back(rnd_req());
                    stim_d_q.push_back(rnd_req());
                end
            endcase
        end
    endtask

    initial begin
        int n;
`ifdef FWRISC_MEM_ARB_STARVE_EN
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        rst = 1'b0;
        #1;
        do_reset(2);
        repeat (5) @(negedge clock);
        #1;

        // Single fetch with a zero-wait memory.
        grant_log.delete();
        mem_q.push_back('{wait_cycles: 0, data: 32'h0000_0013});
        stim_i_q.push_back(mk(32'h8000_0000, 32'd0, 4'd0, 1'b0, 0));
        wait_quiet("single fetch");
        check("single fetch grants", 32'(grant_log.size()), 32'd1);

        // Simultaneous write and fetch: the write goes first.
        grant_log.delete();
        mem_q.push_back('{wait_cycles: 0, data: 32'h1234_5678});
        mem_q.push_back('{wait_cycles: 0, data: 32'h0000_0093});
        stim_d_q.push_back(mk(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1, 0));
        stim_i_q.push_back(mk(32'h8000_0004, 32'd0, 4'd0, 1'b0, 0));
        wait_quiet("simultaneous");
        check("simultaneous grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check_bit("simultaneous first is data", grant_log[0], 1'b1);
            check_bit("simultaneous second is fetch", grant_log[1], 1'b0);
        end

        // Read with five wait states.
        mv_cycles = 0;
        mem_q.push_back('{wait_cycles: 5, data: 32'hCAFE_0204});
        stim_d_q.push_back(mk(32'h0000_0204, 32'd0, 4'd0, 1'b0, 0));
        wait_quiet("wait states");
        check("wait-state m_valid cycles", 32'(mv_cycles), 32'd6);

        // Continuous data traffic with a continuously pending fetch.
        grant_log.delete();
        for (int k = 0; k < 2; k++)
            stim_i_q.push_back(mk(32'h8000_1000 + 32'(k * 4), 32'd0, 4'd0, 1'b0, 0));
        for (int k = 0; k < 4; k++)
            stim_d_q.push_back(mk(32'h0000_2000 + 32'(k * 4), 32'd0, 4'hF, 1'b0, 0));
        wait_quiet("starvation");
        check("starvation grants", 32'(grant_log.size()), 32'd6);
        if (grant_log.size() == 6)
            for (int k = 0; k < 6; k++)
                check_bit($sformatf("starvation grant %0d", k), grant_log[k], exp_seq[k]);

        // Randomised traffic with spurious m_ready and a reset at a random point.
        junk_en = 1'b1;
        push_random(80);
        repeat ($urandom_range(30, 90)) @(negedge clock);
        #($urandom_range(1, 3));
        do_reset(2);
        repeat (6) @(negedge clock);
        #1;
        push_random(120);
        wait_quiet("random traffic");
        junk_en = 1'b0;

        // Reset while the memory is stalling a request.
        mem_q.push_back('{wait_cycles: 20, data: 32'h0BAD_0BAD});
        stim_d_q.push_back(mk(32'h0000_0300, 32'd0, 4'd0, 1'b0, 0));
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check_bit("busy before reset", m_valid, 1'b1);
        #2;
        do_reset(2);
        repeat (8) @(negedge clock);
        #1;

        push_random(40);
        wait_quiet("post-reset traffic");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
